i2c_slave_regfile: RTL and testbench



---
 rtl/i2c_slave_regfile.sv | 335 +++++++++++++++++++++++++++++++++
 tb/tb_i2c_slave_regfile.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_regfile.sv
// -----------------------------------------------------------------------------
// i2c_slave_regfile
//
// I2C target with a small byte-wide register bank. SCL/SDA are oversampled on
// clk, START/STOP are decoded, a 7-bit device address is matched and the
// target then services register writes (dev+W, reg index, data...) and
// register reads (dev+R, data...). A local port lets on-chip logic read the
// bank and observe every committed bus write.
//
// Optional feature macro: I2C_SLAVE_AUTOINC_EN
//   defined   : register pointer advances (mod 2^REG_AW) after every written
//               byte and after every read byte the master ACKs.
//   undefined : pointer stays where the register-index byte put it.
//
// Parameters
//   DEV_ADDR   7-bit device address this target answers to
//   REG_AW     register index width, bank holds 2^REG_AW bytes (REG_AW <= 8)
//   RESET_VAL  reset contents of every register
//
// Ports
//   clk         system clock (at least 8x SCL)
//   rst         synchronous, active-low reset
//   SCL_in      bus clock from the master (asynchronous to clk)
//   SDA_in      resolved bus data (asynchronous to clk)
//   SDA_out     1 = release SDA, 0 = pull SDA low
//   host_addr   local read index
//   host_rdata  combinational read of bank[host_addr]
//   wr_stb      one-cycle pulse per committed bus write
//   wr_addr     register index of the committed write
//   wr_data     byte of the committed write
//   busy        high from START until STOP / abort
// -----------------------------------------------------------------------------
module i2c_slave_regfile #(
  parameter logic [6:0]  DEV_ADDR  = 7'h50,
  parameter int unsigned REG_AW    = 4,
  parameter logic [7:0]  RESET_VAL = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SCL_in,
  input  logic              SDA_in,
  output logic              SDA_out,
  input  logic [REG_AW-1:0] host_addr,
  output logic [7:0]        host_rdata,
  output logic              wr_stb,
  output logic [REG_AW-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy
);

  localparam int unsigned DEPTH = 1 << REG_AW;

  typedef enum logic [3:0] {
    IDLE,
    DEV,
    ACK_DEV,
    REG,
    ACK_REG,
    WDATA,
    ACK_WDATA,
    RDATA,
    MACK
  } state_e;

  // ---------------------------------------------------------------------------
  // Input synchronizers: stages 1-2 resynchronize, stage 3 is the "previous"
  // value used for edge detection. Reset to 1 to match an idle bus.
  // ---------------------------------------------------------------------------
  logic scl_s1_q, scl_s2_q, scl_s3_q;
  logic sda_s1_q, sda_s2_q, sda_s3_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      scl_s1_q <= 1'b1;
      scl_s2_q <= 1'b1;
      scl_s3_q <= 1'b1;
      sda_s1_q <= 1'b1;
      sda_s2_q <= 1'b1;
      sda_s3_q <= 1'b1;
    end else begin
      scl_s1_q <= SCL_in;
      scl_s2_q <= scl_s1_q;
      scl_s3_q <= scl_s2_q;
      sda_s1_q <= SDA_in;
      sda_s2_q <= sda_s1_q;
      sda_s3_q <= sda_s2_q;
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;

  assign scl_rise  =  scl_s2_q & ~scl_s3_q;
  assign scl_fall  = ~scl_s2_q &  scl_s3_q;
  // SCL must be high in both compared samples so an SDA change that races an
  // SCL edge is not mistaken for a bus condition.
  assign start_det =  scl_s2_q &  scl_s3_q &  sda_s3_q & ~sda_s2_q;
  assign stop_det  =  scl_s2_q &  scl_s3_q & ~sda_s3_q &  sda_s2_q;

  // ---------------------------------------------------------------------------
  // Register bank: one cell per index, written from the registered commit
  // strobe so host_rdata shows the new value the cycle after wr_stb.
  // ---------------------------------------------------------------------------
  logic [7:0]        bank_w [DEPTH];
  logic              wr_stb_q;
  logic [REG_AW-1:0] wr_addr_q;
  logic [7:0]        wr_data_q;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_bank
      logic [7:0] cell_q;

      always_ff @(posedge clk) begin
        if (!rst) begin
          cell_q <= RESET_VAL;
        end else if (wr_stb_q && (wr_addr_q == REG_AW'(gi))) begin
          cell_q <= wr_data_q;
        end
      end

      assign bank_w[gi] = cell_q;
    end
  endgenerate

  assign host_rdata = bank_w[host_addr];

  // ---------------------------------------------------------------------------
  // Protocol FSM
  // ---------------------------------------------------------------------------
  state_e            state_q;
  logic [3:0]        bit_cnt_q;
  logic [7:0]        shift_q;
  logic [REG_AW-1:0] ptr_q;
  logic              rw_q;
  logic              ack_drv_q;   // ACK low currently being driven
  logic              sda_out_q;
  logic              busy_q;

  logic [7:0]        rx_byte;
  logic              last_bit;
  logic [REG_AW-1:0] ptr_adv;
  logic [7:0]        rd_byte;
  logic [7:0]        rd_next;

  // Byte as it stands once the bit sampled on this SCL rising edge is added.
  assign rx_byte  = {shift_q[6:0], sda_s2_q};
  assign last_bit = (bit_cnt_q == 4'd7);

`ifdef I2C_SLAVE_AUTOINC_EN
  assign ptr_adv = ptr_q + REG_AW'(1);
`else
  assign ptr_adv = ptr_q;
`endif

  assign rd_byte = bank_w[ptr_q];
  assign rd_next = bank_w[ptr_adv];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= 4'd0;
      shift_q   <= 8'h00;
      ptr_q     <= '0;
      rw_q      <= 1'b0;
      ack_drv_q <= 1'b0;
      sda_out_q <= 1'b1;
      busy_q    <= 1'b0;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= 8'h00;
    end else begin
      wr_stb_q <= 1'b0;

      if (stop_det) begin
        state_q   <= IDLE;
        sda_out_q <= 1'b1;
        busy_q    <= 1'b0;
        ack_drv_q <= 1'b0;
      end else if (start_det) begin
        // Covers repeated START too; ptr_q is deliberately kept.
        state_q   <= DEV;
        bit_cnt_q <= 4'd0;
        sda_out_q <= 1'b1;
        busy_q    <= 1'b1;
        ack_drv_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            sda_out_q <= 1'b1;
            busy_q    <= 1'b0;
          end

          DEV: begin
            if (scl_rise) begin
              shift_q   <= rx_byte;
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (last_bit) begin
                bit_cnt_q <= 4'd0;
                if (rx_byte[7:1] == DEV_ADDR) begin
                  rw_q      <= rx_byte[0];
                  ack_drv_q <= 1'b0;
                  state_q   <= ACK_DEV;
                end else begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                end
              end
            end
          end

          ACK_DEV: begin
            if (scl_fall) begin
              if (!ack_drv_q) begin
                sda_out_q <= 1'b0;
                ack_drv_q <= 1'b1;
              end else begin
                ack_drv_q <= 1'b0;
                if (rw_q) begin
                  // The falling edge that ends the ACK also launches bit 7.
                  sda_out_q <= rd_byte[7];
                  shift_q   <= {rd_byte[6:0], 1'b0};
                  bit_cnt_q <= 4'd1;
                  state_q   <= RDATA;
                end else begin
                  sda_out_q <= 1'b1;
                  bit_cnt_q <= 4'd0;
                  state_q   <= REG;
                end
              end
            end
          end

          REG: begin
            if (scl_rise) begin
              shift_q   <= rx_byte;
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (last_bit) begin
                bit_cnt_q <= 4'd0;
                ptr_q     <= rx_byte[REG_AW-1:0];
                ack_drv_q <= 1'b0;
                state_q   <= ACK_REG;
              end
            end
          end

          ACK_REG: begin
            if (scl_fall) begin
              if (!ack_drv_q) begin
                sda_out_q <= 1'b0;
                ack_drv_q <= 1'b1;
              end else begin
                sda_out_q <= 1'b1;
                ack_drv_q <= 1'b0;
                bit_cnt_q <= 4'd0;
                state_q   <= WDATA;
              end
            end
          end

          WDATA: begin
            if (scl_rise) begin
              shift_q   <= rx_byte;
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (last_bit) begin
                bit_cnt_q <= 4'd0;
                ack_drv_q <= 1'b0;
                state_q   <= ACK_WDATA;
              end
            end
          end

          ACK_WDATA: begin
            if (scl_fall) begin
              if (!ack_drv_q) begin
                // Byte is complete: commit it as the ACK goes out.
                sda_out_q <= 1'b0;
                ack_drv_q <= 1'b1;
                wr_stb_q  <= 1'b1;
                wr_addr_q <= ptr_q;
                wr_data_q <= shift_q;
                ptr_q     <= ptr_adv;
              end else begin
                sda_out_q <= 1'b1;
                ack_drv_q <= 1'b0;
                bit_cnt_q <= 4'd0;
                state_q   <= WDATA;
              end
            end
          end

          RDATA: begin
            if (scl_fall) begin
              if (bit_cnt_q == 4'd8) begin
                // All 8 bits shown; free the line for the master's ACK/NACK.
                sda_out_q <= 1'b1;
                state_q   <= MACK;
              end else begin
                sda_out_q <= shift_q[7];
                shift_q   <= {shift_q[6:0], 1'b0};
                bit_cnt_q <= bit_cnt_q + 4'd1;
              end
            end
          end

          MACK: begin
            if (scl_rise) begin
              if (!sda_s2_q) begin
                ptr_q     <= ptr_adv;
                shift_q   <= rd_next;
                bit_cnt_q <= 4'd0;
                state_q   <= RDATA;
              end else begin
                sda_out_q <= 1'b1;
                busy_q    <= 1'b0;
                state_q   <= IDLE;
              end
            end
          end

          default: begin
            sda_out_q <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end
        endcase
      end
    end
  end

  assign SDA_out = sda_out_q;
  assign busy    = busy_q;
  assign wr_stb  = wr_stb_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// -----------------------------------------------------------------------------
// Testbench for i2c_slave_regfile (default parameters). Acts as the I2C
// master, keeps a model of the register bank and pointer, and checks every
// committed write through a scoreboard queue of expected {addr, data}.
// -----------------------------------------------------------------------------
module tb_i2c_slave_regfile;

  localparam int QCLK = 8;  // clk cycles per quarter SCL period

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic [3:0] host_addr = 4'd0;
  logic       sda_out_w;
  logic [7:0] host_rdata;
  logic       wr_stb;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  logic       sda_bus;

  assign sda_bus = sda_m & sda_out_w;

  always #5 clk = ~clk;

  i2c_slave_regfile dut (
    .clk        (clk),
    .rst        (rst),
    .SCL_in     (scl_m),
    .SDA_in     (sda_bus),
    .SDA_out    (sda_out_w),
    .host_addr  (host_addr),
    .host_rdata (host_rdata),
    .wr_stb     (wr_stb),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy)
  );

  int checks   = 0;
  int failures = 0;

  logic [11:0] sb_q[$];
  logic [11:0] sb_exp;
  logic [7:0]  mbank [16];
  logic [3:0]  mptr;

  int   sda_low_cnt = 0;
  int   glitch_cnt  = 0;
  int   scl_hi_cnt  = 0;
  logic sda_prev    = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboard consumer: every strobe must match the oldest expected commit.
  always @(negedge clk) begin
    if (rst && wr_stb) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL wr_stb_unexpected actual=%0h:%0h required=no strobe", wr_addr, wr_data);
      end else begin
        sb_exp = sb_q.pop_front();
        chk("wr_commit", {20'd0, wr_addr, wr_data}, {20'd0, sb_exp});
      end
    end
  end

  // Bus observers: cycles SDA is pulled low, and SDA_out changes while SCL
  // has been high for a while (target must only move SDA with SCL low).
  always @(negedge clk) begin
    if (!sda_out_w) sda_low_cnt <= sda_low_cnt + 1;
    scl_hi_cnt <= scl_m ? scl_hi_cnt + 1 : 0;
    sda_prev   <= sda_out_w;
    if (rst && scl_m && (scl_hi_cnt > 4) && (sda_out_w !== sda_prev))
      glitch_cnt <= glitch_cnt + 1;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Master bit/byte primitives
  // ---------------------------------------------------------------------------
  task automatic wait_q();
    repeat (QCLK) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b1; wait_q();
  endtask

  task automatic send_bit(input logic b);
    sda_m = b;    wait_q();
    scl_m = 1'b1; wait_q(); wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic recv_bit(output logic b);
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    b = sda_bus;  wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic write_byte(input logic [7:0] b, output logic nack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    recv_bit(nack);
  endtask

  task automatic read_byte(output logic [7:0] b, input logic mnack, output logic rel);
    logic bb;
    b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      recv_bit(bb);
      b = {b[6:0], bb};
    end
    sda_m = mnack; wait_q();
    rel = sda_out_w;
    scl_m = 1'b1; wait_q(); wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic check_bank(input string name);
    for (int a = 0; a < 16; a++) begin
      host_addr = 4'(a);
      #1;
      chk(name, {24'd0, host_rdata}, {24'd0, mbank[a]});
    end
  endtask

  task automatic model_reset();
    for (int a = 0; a < 16; a++) mbank[a] = 8'h00;
    mptr = 4'd0;
  endtask

  // ---------------------------------------------------------------------------
  // Write vectors
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [7:0] dev_b;
    logic [7:0] reg_b;
    int         n;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       exp_ack;
  } wvec_t;

  wvec_t wtab [5];

  task automatic run_write(input wvec_t v);
    logic       nack;
    logic [7:0] d;
    int         low0;
    low0 = sda_low_cnt;
    i2c_start();
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    write_byte(v.dev_b, nack);
    chk("dev_ack", {31'd0, nack}, {31'd0, !v.exp_ack});
    write_byte(v.reg_b, nack);
    chk("reg_ack", {31'd0, nack}, {31'd0, !v.exp_ack});
    if (v.exp_ack) mptr = v.reg_b[3:0];
    for (int k = 0; k < v.n; k++) begin
      d = (k == 0) ? v.d0 : v.d1;
      if (v.exp_ack) begin
        sb_q.push_back({mptr, d});
        mbank[mptr] = d;
`ifdef I2C_SLAVE_AUTOINC_EN
        mptr = mptr + 4'd1;
`endif
      end
      write_byte(d, nack);
      chk("data_ack", {31'd0, nack}, {31'd0, !v.exp_ack});
    end
    i2c_stop();
    repeat (4) @(posedge clk);
    #1;
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_sda_out", {31'd0, sda_out_w}, 32'd1);
    chk("sb_drained", sb_q.size(), 32'd0);
    if (!v.exp_ack) chk("nomatch_sda_low", sda_low_cnt - low0, 32'd0);
    check_bank("bank_after_write");
    $display("txn write dev=%02h reg=%02h n=%0d d0=%02h d1=%02h ack=%0d",
             v.dev_b, v.reg_b, v.n, v.d0, v.d1, v.exp_ack);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic       nack;
    logic       rel;
    logic [7:0] rb;

    wtab[0] = '{dev_b: 8'hA0, reg_b: 8'hF3, n: 1, d0: 8'h77, d1: 8'h00, exp_ack: 1'b1};
    wtab[1] = '{dev_b: 8'hA0, reg_b: 8'h03, n: 1, d0: 8'h5A, d1: 8'h00, exp_ack: 1'b1};
    wtab[2] = '{dev_b: 8'hA2, reg_b: 8'h03, n: 1, d0: 8'h99, d1: 8'h00, exp_ack: 1'b0};
    wtab[3] = '{dev_b: 8'hA0, reg_b: 8'h0F, n: 2, d0: 8'h11, d1: 8'h22, exp_ack: 1'b1};
    wtab[4] = '{dev_b: 8'hA0, reg_b: 8'h07, n: 1, d0: 8'hC3, d1: 8'h00, exp_ack: 1'b1};

    model_reset();

    // Reset state
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sda_out", {31'd0, sda_out_w}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_wr_stb", {31'd0, wr_stb}, 32'd0);
    chk("rst_wr_addr", {28'd0, wr_addr}, 32'd0);
    chk("rst_wr_data", {24'd0, wr_data}, 32'd0);
    check_bank("rst_bank");
    $display("txn reset");

    // Table-driven writes
    for (int v = 0; v < 5; v++) run_write(wtab[v]);

    // Read: reg 3, repeated START, single byte, master NACK
    i2c_start();
    write_byte(8'hA0, nack); chk("rd_dev_w_ack", {31'd0, nack}, 32'd0);
    write_byte(8'h03, nack); chk("rd_reg_ack", {31'd0, nack}, 32'd0);
    mptr = 4'd3;
    i2c_start();
    write_byte(8'hA1, nack); chk("rd_dev_r_ack", {31'd0, nack}, 32'd0);
    read_byte(rb, 1'b1, rel);
    chk("rd_byte", {24'd0, rb}, {24'd0, mbank[mptr]});
    chk("rd_released", {31'd0, rel}, 32'd1);
    i2c_stop();
    repeat (4) @(posedge clk);
    #1;
    chk("rd_busy_after_stop", {31'd0, busy}, 32'd0);
    $display("txn read reg=03 data=%02h", rb);

    // Burst read from reg 15: master ACKs first byte, NACKs second
    i2c_start();
    write_byte(8'hA0, nack); chk("brd_dev_w_ack", {31'd0, nack}, 32'd0);
    write_byte(8'h0F, nack); chk("brd_reg_ack", {31'd0, nack}, 32'd0);
    mptr = 4'hF;
    i2c_start();
    write_byte(8'hA1, nack); chk("brd_dev_r_ack", {31'd0, nack}, 32'd0);
    read_byte(rb, 1'b0, rel);
    chk("brd_byte0", {24'd0, rb}, {24'd0, mbank[mptr]});
`ifdef I2C_SLAVE_AUTOINC_EN
    mptr = mptr + 4'd1;
`endif
    read_byte(rb, 1'b1, rel);
    chk("brd_byte1", {24'd0, rb}, {24'd0, mbank[mptr]});
    i2c_stop();
    repeat (4) @(posedge clk);
    #1;
    chk("brd_busy", {31'd0, busy}, 32'd0);
    $display("txn burst-read reg=0f last=%02h", rb);

    // STOP after 4 data bits: byte discarded
    i2c_start();
    write_byte(8'hA0, nack);
    write_byte(8'h05, nack);
    mptr = 4'd5;
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    i2c_stop();
    repeat (4) @(posedge clk);
    #1;
    chk("stop_mid_sda_out", {31'd0, sda_out_w}, 32'd1);
    chk("stop_mid_busy", {31'd0, busy}, 32'd0);
    chk("stop_mid_sb", sb_q.size(), 32'd0);
    check_bank("stop_mid_bank");
    $display("txn stop-mid-byte reg=05");

    // Reset asserted mid-byte
    i2c_start();
    write_byte(8'hA0, nack);
    write_byte(8'h06, nack);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mid_sda_out", {31'd0, sda_out_w}, 32'd1);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    scl_m = 1'b1;
    sda_m = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    repeat (4) @(posedge clk);
    #1;
    check_bank("rst_mid_bank");
    $display("txn reset-mid-byte reg=06");

    // Target still works after the abort
    run_write(wtab[4]);

    chk("sda_stable_scl_high", glitch_cnt, 32'd0);
    chk("sb_final_empty", sb_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
